shot_cmd_rx: RTL and testbench
==============================

Name: shot_cmd_rx

Overview:
Upstream command front-end for the dual motor controller. Oversamples the host SPI link (sck/sdi) in the clk domain and assembles 24-bit frames {azimuth, polar, force}. Range-checks each frame and drives the motor/relay stage's position, force and load inputs. Sequences load through aim, fire and release, so the host only sends frames and never toggles load itself.

Parameters:
SYNC_STAGES, 2, synchroniser depth on sck and sdi (min 2)
TIMEOUT_CYCLES, 65536, clk cycles without an sck rising edge before a partial frame is discarded
MAX_POS, 95, largest legal azimuth/polar position (revolutions)
MAX_FORCE, 200, largest legal forceCount; 0 is always illegal
RELEASE_CYCLES, 262144, clk cycles load is held low after a shot or abort (covers two 2^17 motor slowclk periods)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sck  in  1  host SPI clock, asynchronous to clk
sdi  in  1  host SPI data, MSB first, valid on sck rising edge
abort  in  1  host/e-stop abort request, level
aziDone  in  1  azimuth motor at target
polDone  in  1  polar motor at target
solenoid_relay  in  1  solenoid relay drive from relay stage
aziPosition  out  8  latched azimuth target
polPosition  out  8  latched polar target
forceCount  out  8  latched compressor time
load  out  1  command-valid/arm to motor and relay stages
busy  out  1  high in any state other than IDLE
frameErr  out  1  1-cycle pulse: timeout or range failure
overrun  out  1  1-cycle pulse: valid-length frame completed while busy

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0, timeout counter 0, shift register 0.
- sck and sdi each pass through SYNC_STAGES flops. Edge detect on synchronised sck. sdi is sampled in the same cycle the rising edge is detected.
- Shift register is 24 bits, MSB first: bits 23:16 azimuth, 15:8 polar, 7:0 force. The bit counter increments per edge. The 24th edge sets frame_done for exactly one cycle, and the counter returns to 0.
- Timeout: the counter runs while bit counter != 0 and clears on each sck edge. At TIMEOUT_CYCLES it clears the bit counter and pulses frameErr. It saturates and does not re-fire.
- Validity: azi<=MAX_POS, pol<=MAX_POS, 1<=force<=MAX_FORCE.
- FSM states: IDLE, ARMED, FIRING, RELEASE.
- IDLE: on frame_done && valid, the next clk edge latches aziPosition/polPosition/forceCount, sets load=1 and moves to ARMED. Latency is 1 clk from the cycle frame_done is high. On frame_done && !valid, pulse frameErr, leave outputs unchanged and stay in IDLE.
- ARMED: when aziDone && polDone, go to FIRING.
- FIRING: track seen_high when solenoid_relay=1. On a 1->0 transition of solenoid_relay with seen_high set, set load=0 and go to RELEASE.
- RELEASE: load=0. A counter runs for RELEASE_CYCLES, then the FSM goes to IDLE and busy drops in the same cycle.
- abort=1 in ARMED or FIRING: next cycle load=0, enter RELEASE with the counter restarted. Abort takes priority over done/fire events in the same cycle. In IDLE and RELEASE, abort is ignored.
- frame_done in any state != IDLE: pulse overrun, discard the frame, leave latched outputs unchanged. frame_done in the final RELEASE cycle also counts as overrun, because the state is still != IDLE.
- Latched outputs change only on an accepted frame and hold through RELEASE.
- rst mid-frame or mid-shot: everything returns to reset values on the next edge, load=0.
- The SPI shifter keeps running in every state, so frames are never misaligned.

Optional Feature:
CMD_CHECKSUM_EN:
- Defined: the frame is 32 bits, with bits 7:0 a checksum equal to (azi+pol+force) mod 256. frame_done fires on the 32nd edge. A checksum mismatch is treated as a validity failure (frameErr pulse, frame dropped).
- Undefined: frame is 24 bits with no checksum, as above.

Test Plan:
- rst, then send 0x0A,0x1A,0x0A -> load=1 exactly 1 clk after frame_done; aziPosition=0x0A, polPosition=0x1A, forceCount=0x0A; busy=1.
- Accepted frame, aziDone=polDone=1, solenoid_relay pulses 0->1->0 -> FIRING, then load=0; busy stays 1 for RELEASE_CYCLES; IDLE afterwards.
- Send azi=0x60 (96 > MAX_POS) -> frameErr single pulse, load stays 0, outputs keep prior values.
- Send 10 bits, then idle TIMEOUT_CYCLES, then a full valid frame -> one frameErr pulse; second frame accepted with correct byte alignment.
- In ARMED, send a new valid frame -> overrun pulse, outputs unchanged. Then abort=1 in the same cycle as aziDone&polDone -> load=0, RELEASE, FIRING never entered.
- With CMD_CHECKSUM_EN: frame 0x02,0x02,0x28,0x2C accepted; frame 0x02,0x02,0x28,0x2D -> frameErr, no load.

Source files
------------

// File: rtl/shot_cmd_rx.sv
// shot_cmd_rx: oversampled SPI command receiver that range-checks frames and sequences load.
// Optional CMD_CHECKSUM_EN: 32-bit frames carrying a trailing (azi+pol+force) mod 256 byte.
module shot_cmd_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_POS        = 95,
    parameter int MAX_FORCE      = 200,
    parameter int RELEASE_CYCLES = 262144
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       sdi,
    input  logic       abort,
    input  logic       aziDone,
    input  logic       polDone,
    input  logic       solenoid_relay,
    output logic [7:0] aziPosition,
    output logic [7:0] polPosition,
    output logic [7:0] forceCount,
    output logic       load,
    output logic       busy,
    output logic       frameErr,
    output logic       overrun
);

`ifdef CMD_CHECKSUM_EN
    localparam int FRAME_BITS = 32;
`else
    localparam int FRAME_BITS = 24;
`endif
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RC_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [4:0]      LAST_BIT    = 5'(FRAME_BITS - 1);
    localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT_CYCLES);
    localparam logic [RC_W-1:0] REL_LAST    = RC_W'(RELEASE_CYCLES - 1);
    localparam logic [7:0]      MAX_POS_B   = 8'(MAX_POS);
    localparam logic [7:0]      MAX_FORCE_B = 8'(MAX_FORCE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        FIRING  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] sdi_sync_r;
    logic                   sck_prev_r;
    logic [FRAME_BITS-1:0]  shift_r;
    logic [4:0]             bit_cnt_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic                   frame_done_r;
    logic                   timeout_r;
    logic [RC_W-1:0]        rel_cnt_r;
    logic                   seen_high_r;
    logic                   relay_prev_r;
    state_e                 state_r;

    logic       sck_rise_s;
    logic       sdi_s;
    logic       cks_ok_s;
    logic       frame_ok_s;
    logic [7:0] azi_s;
    logic [7:0] pol_s;
    logic [7:0] frc_s;

    function automatic logic range_ok(input logic [7:0] a, input logic [7:0] p, input logic [7:0] f);
        return (a <= MAX_POS_B) && (p <= MAX_POS_B) && (f != 8'd0) && (f <= MAX_FORCE_B);
    endfunction

`ifdef CMD_CHECKSUM_EN
    function automatic logic [7:0] cmd_sum(input logic [7:0] a, input logic [7:0] p, input logic [7:0] f);
        return a + p + f;
    endfunction
    assign cks_ok_s = (cmd_sum(azi_s, pol_s, frc_s) == shift_r[7:0]);
`else
    assign cks_ok_s = 1'b1;
`endif

    assign sck_rise_s = sck_sync_r[SYNC_STAGES-1] & ~sck_prev_r;
    assign sdi_s      = sdi_sync_r[SYNC_STAGES-1];
    assign azi_s      = shift_r[FRAME_BITS-1  -: 8];
    assign pol_s      = shift_r[FRAME_BITS-9  -: 8];
    assign frc_s      = shift_r[FRAME_BITS-17 -: 8];
    assign frame_ok_s = range_ok(azi_s, pol_s, frc_s) && cks_ok_s;

    // Bring sck/sdi into the clk domain and remember the last synchronised sck level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_r <= {SYNC_STAGES{1'b0}};
            sdi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_prev_r <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
            sck_prev_r <= sck_sync_r[SYNC_STAGES-1];
        end
    end

    // Frame shifter with bit counter and a saturating inactivity timeout; runs in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r      <= {FRAME_BITS{1'b0}};
            bit_cnt_r    <= 5'd0;
            to_cnt_r     <= {TO_W{1'b0}};
            frame_done_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            timeout_r    <= 1'b0;
            if (sck_rise_s) begin
                shift_r  <= {shift_r[FRAME_BITS-2:0], sdi_s};
                to_cnt_r <= {TO_W{1'b0}};
                if (bit_cnt_r == LAST_BIT) begin
                    bit_cnt_r    <= 5'd0;
                    frame_done_r <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                end
            end else if ((bit_cnt_r != 5'd0) && (to_cnt_r != TO_MAX)) begin
                to_cnt_r <= to_cnt_r + 1'b1;
                if (to_cnt_r == (TO_MAX - 1'b1)) begin
                    bit_cnt_r <= 5'd0;
                    timeout_r <= 1'b1;
                end
            end
        end
    end

    // Shot sequencer: accept frame, wait for aim, watch the solenoid pulse, then hold load low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            aziPosition  <= 8'd0;
            polPosition  <= 8'd0;
            forceCount   <= 8'd0;
            load         <= 1'b0;
            busy         <= 1'b0;
            frameErr     <= 1'b0;
            overrun      <= 1'b0;
            rel_cnt_r    <= {RC_W{1'b0}};
            seen_high_r  <= 1'b0;
            relay_prev_r <= 1'b0;
        end else begin
            frameErr     <= timeout_r;
            overrun      <= frame_done_r && (state_r != IDLE);
            relay_prev_r <= solenoid_relay;
            case (state_r)
                IDLE: begin
                    if (frame_done_r) begin
                        if (frame_ok_s) begin
                            aziPosition <= azi_s;
                            polPosition <= pol_s;
                            forceCount  <= frc_s;
                            load        <= 1'b1;
                            busy        <= 1'b1;
                            state_r     <= ARMED;
                        end else begin
                            frameErr <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (abort) begin
                        load      <= 1'b0;
                        rel_cnt_r <= {RC_W{1'b0}};
                        state_r   <= RELEASE;
                    end else if (aziDone && polDone) begin
                        seen_high_r <= 1'b0;
                        state_r     <= FIRING;
                    end
                end
                FIRING: begin
                    if (abort) begin
                        load      <= 1'b0;
                        rel_cnt_r <= {RC_W{1'b0}};
                        state_r   <= RELEASE;
                    end else begin
                        if (solenoid_relay) begin
                            seen_high_r <= 1'b1;
                        end
                        if (relay_prev_r && !solenoid_relay && seen_high_r) begin
                            load      <= 1'b0;
                            rel_cnt_r <= {RC_W{1'b0}};
                            state_r   <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    load <= 1'b0;
                    if (rel_cnt_r == REL_LAST) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        rel_cnt_r <= rel_cnt_r + 1'b1;
                    end
                end
                default: begin
                    load    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_cmd_rx.sv
// Scoreboard bench for shot_cmd_rx: stimulus queues expected events, a negedge monitor checks them.
module tb_shot_cmd_rx;

    localparam int TO_C  = 300;
    localparam int REL_C = 50;
`ifdef CMD_CHECKSUM_EN
    localparam int NB = 32;
`else
    localparam int NB = 24;
`endif

    logic       clk = 1'b0;
    logic       rst, sck, sdi, abort, aziDone, polDone, solenoid_relay;
    logic [7:0] aziPosition, polPosition, forceCount;
    logic       load, busy, frameErr, overrun;

    shot_cmd_rx #(
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_C), .MAX_POS(95),
        .MAX_FORCE(200), .RELEASE_CYCLES(REL_C)
    ) dut (
        .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .abort(abort),
        .aziDone(aziDone), .polDone(polDone), .solenoid_relay(solenoid_relay),
        .aziPosition(aziPosition), .polPosition(polPosition), .forceCount(forceCount),
        .load(load), .busy(busy), .frameErr(frameErr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_LOAD, EV_ERR, EV_OVR, EV_REL, EV_IDLE} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] a, p, f;
        bit         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    time  last_rise_t = 0;
    time  last_fall_t = 0;
    logic load_q = 1'b0;
    logic busy_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_e k, input logic [7:0] a, input logic [7:0] p,
                             input logic [7:0] f, input bit lat);
        exp_t e;
        e.kind = k; e.a = a; e.p = p; e.f = f; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input ev_e k);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_%s: got unexpected event, expected none", k.name());
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            errors++;
            $display("FAIL event_order: got %s expected %s", k.name(), e.kind.name());
            return;
        end
        if (k == EV_LOAD) begin
            chk("azi_latched", 32'(aziPosition), 32'(e.a));
            chk("pol_latched", 32'(polPosition), 32'(e.p));
            chk("force_latched", 32'(forceCount), 32'(e.f));
            chk("busy_at_load", 32'(busy), 32'd1);
        end
        if (e.lat) begin
            chk("frame_latency", 32'($time - last_rise_t), 32'd40);
        end
        if (k == EV_IDLE) begin
            chk("release_len", 32'($time - last_fall_t), 32'(REL_C * 10));
        end
    endtask

    // Monitor: turn DUT output activity into events and compare against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (frameErr) got_ev(EV_ERR);
            if (overrun) got_ev(EV_OVR);
            if (load && !load_q) got_ev(EV_LOAD);
            if (!load && load_q) begin
                last_fall_t <= $time;
                got_ev(EV_REL);
            end
            if (!busy && busy_q) got_ev(EV_IDLE);
        end
        load_q <= load;
        busy_q <= busy;
    end

    function automatic logic [31:0] frm(input logic [7:0] a, input logic [7:0] p, input logic [7:0] f);
`ifdef CMD_CHECKSUM_EN
        logic [7:0] s;
        s = a + p + f;
        return {a, p, f, s};
`else
        return {8'h00, a, p, f};
`endif
    endfunction

    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk); sck = 1'b0; sdi = d[i];
            repeat (3) @(negedge clk);
            @(negedge clk); sck = 1'b1; last_rise_t = $time;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < REL_C + 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sck = 1'b0; sdi = 1'b0; abort = 1'b0;
        aziDone = 1'b0; polDone = 1'b0; solenoid_relay = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_azi", 32'(aziPosition), 32'd0);
        chk("rst_pol", 32'(polPosition), 32'd0);
        chk("rst_force", 32'(forceCount), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({frameErr, overrun}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Accepted frame, then a full aim/fire/release cycle
        expect_ev(EV_LOAD, 8'h0A, 8'h1A, 8'h0A, 1'b1);
        send_bits(frm(8'h0A, 8'h1A, 8'h0A), NB);
        chk("load_armed", 32'(load), 32'd1);
        aziDone = 1'b1; polDone = 1'b1;
        repeat (3) @(negedge clk);
        chk("load_firing", 32'(load), 32'd1);
        expect_ev(EV_REL, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_ev(EV_IDLE, 8'h00, 8'h00, 8'h00, 1'b0);
        solenoid_relay = 1'b1;
        repeat (3) @(negedge clk);
        solenoid_relay = 1'b0; aziDone = 1'b0; polDone = 1'b0;
        repeat (2) @(negedge clk);
        chk("load_after_shot", 32'(load), 32'd0);
        chk("busy_release", 32'(busy), 32'd1);
        wait_idle("idle_after_shot");
        chk("azi_hold", 32'(aziPosition), 32'h0A);

        // Range failures, including each boundary just outside the legal window
        expect_ev(EV_ERR, 8'h00, 8'h00, 8'h00, 1'b1);
        send_bits(frm(8'h60, 8'h10, 8'h10), NB);
        chk("load_after_bad", 32'(load), 32'd0);
        chk("azi_after_bad", 32'(aziPosition), 32'h0A);
        chk("pol_after_bad", 32'(polPosition), 32'h1A);
        expect_ev(EV_ERR, 8'h00, 8'h00, 8'h00, 1'b1);
        send_bits(frm(8'h10, 8'h60, 8'h10), NB);
        expect_ev(EV_ERR, 8'h00, 8'h00, 8'h00, 1'b1);
        send_bits(frm(8'h10, 8'h10, 8'h00), NB);
        expect_ev(EV_ERR, 8'h00, 8'h00, 8'h00, 1'b1);
        send_bits(frm(8'h10, 8'h10, 8'hC9), NB);
        chk("busy_after_bad", 32'(busy), 32'd0);

        // Largest legal values, released by abort from ARMED
        expect_ev(EV_LOAD, 8'h5F, 8'h5F, 8'hC8, 1'b1);
        send_bits(frm(8'h5F, 8'h5F, 8'hC8), NB);
        expect_ev(EV_REL, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_ev(EV_IDLE, 8'h00, 8'h00, 8'h00, 1'b0);
        pulse_abort();
        wait_idle("idle_after_abort");

        // Partial frame times out; following frame must be byte-aligned
        expect_ev(EV_ERR, 8'h00, 8'h00, 8'h00, 1'b0);
        send_bits(32'h0000_03FF, 10);
        repeat (TO_C + 20) @(negedge clk);
        expect_ev(EV_LOAD, 8'h11, 8'h22, 8'h33, 1'b1);
        send_bits(frm(8'h11, 8'h22, 8'h33), NB);

        // Frame while ARMED is an overrun; abort beats done in the same cycle
        expect_ev(EV_OVR, 8'h00, 8'h00, 8'h00, 1'b1);
        send_bits(frm(8'h01, 8'h02, 8'h03), NB);
        chk("azi_after_ovr", 32'(aziPosition), 32'h11);
        chk("force_after_ovr", 32'(forceCount), 32'h33);
        chk("load_after_ovr", 32'(load), 32'd1);
        expect_ev(EV_REL, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_ev(EV_IDLE, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk); abort = 1'b1; aziDone = 1'b1; polDone = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_priority", 32'(load), 32'd0);
        @(negedge clk); aziDone = 1'b0; polDone = 1'b0;
        wait_idle("idle_after_abort_done");

        // Abort held in IDLE does not block acceptance, then releases from ARMED
        abort = 1'b1;
        expect_ev(EV_LOAD, 8'h2A, 8'h00, 8'h01, 1'b1);
        expect_ev(EV_REL, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_ev(EV_IDLE, 8'h00, 8'h00, 8'h00, 1'b0);
        send_bits(frm(8'h2A, 8'h00, 8'h01), NB);
        abort = 1'b0;
        wait_idle("idle_after_idle_abort");

`ifdef CMD_CHECKSUM_EN
        expect_ev(EV_LOAD, 8'h02, 8'h02, 8'h28, 1'b1);
        send_bits(32'h0202_282C, NB);
        expect_ev(EV_REL, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_ev(EV_IDLE, 8'h00, 8'h00, 8'h00, 1'b0);
        pulse_abort();
        wait_idle("idle_after_cks");
        expect_ev(EV_ERR, 8'h00, 8'h00, 8'h00, 1'b1);
        send_bits(32'h0202_282D, NB);
        chk("load_bad_cks", 32'(load), 32'd0);
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
